data_mem_resp: RTL and testbench
================================

DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 512, number of 32-bit words stored.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 SHALL have port CLOCK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET, input, 1, synchronous active-low reset, sampled on the rising edge of CLOCK.
REQ-005 SHALL have port ReqValid, input, 1, initiator (MEM stage) presents a request.
REQ-006 SHALL have port ReqReady, output, 1, responder can accept a request this cycle.
REQ-007 SHALL have port ReqWrite, input, 1, 1 = store word, 0 = load word.
REQ-008 SHALL have port ReqAddr, input, 32, byte address.
REQ-009 SHALL have port ReqWData, input, 32, store data.
REQ-010 SHALL have port RespValid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port RespRData, output, 32, load data, valid only while RespValid=1.
REQ-012 SHALL have port RespErr, output, 1, request was misaligned or out of range, valid only while RespValid=1.
REQ-013 SHALL have port Busy, output, 1, request in flight; drives the CPU pipeline stall.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESPOND; transitions: IDLE->ACCESS on handshake; ACCESS->RESPOND unconditionally; RESPOND->IDLE unconditionally.
REQ-015 SHALL assert ReqReady=1 only in IDLE; handshake = ReqValid & ReqReady at a rising edge.
REQ-016 SHALL capture ReqWrite, ReqAddr, ReqWData into internal registers on handshake; later input changes have no effect on that request.
REQ-017 SHALL perform the array read or write at the ACCESS->RESPOND edge using only the captured values.
REQ-018 SHALL assert RespValid for exactly one cycle, in RESPOND, i.e. 2 cycles after the handshake edge; throughput is one request per 3 cycles.
REQ-019 SHALL assert Busy=1 in ACCESS and RESPOND and 0 in IDLE.
REQ-020 SHALL compute the word index as (addr - BASE_ADDR) >> 2, using 32-bit unsigned subtraction with wrap-around.
REQ-021 SHALL flag an error when addr[1:0] != 0, addr < BASE_ADDR, or the word index >= DEPTH_WORDS.
REQ-022 SHALL, on an error, leave memory unchanged and return RespRData=0 and RespErr=1.
REQ-023 SHALL return RespRData=0 and RespErr=0 for a successful store; a successful load returns the stored word and RespErr=0.
REQ-024 SHALL drive RespRData=0 and RespErr=0 whenever RespValid=0.
REQ-025 SHALL ignore ReqValid while in ACCESS or RESPOND; no request is queued.
REQ-026 SHALL treat a load immediately after a store to the same address as returning the new data.

Reset
REQ-027 SHALL, when RESET=0 at a rising edge, enter IDLE and drive ReqReady=1, RespValid=0, RespRData=0, RespErr=0, Busy=0 from the next cycle.
REQ-028 SHALL clear all memory words to 0 on reset.
REQ-029 SHALL give reset priority over all other events; a store whose ACCESS edge coincides with reset is not performed, and no RespValid is produced for an aborted request.

Structure
REQ-030 SHALL place the FSM state encoding (IDLE=2'd0, ACCESS=2'd1, RESPOND=2'd2) and the default DEPTH_WORDS constant in the shared CPU package.
REQ-031 SHALL keep the storage in one sub-module, word_ram, containing the synchronous single-port array with a reset clear; the FSM, decode, and error check stay in data_mem_resp.

Verification
REQ-032 Reset check: reset, then store 0xDEADBEEF to addr 0x10; load 0x10 -> RespValid exactly 2 cycles after each handshake; load returns 0xDEADBEEF with RespErr=0.
REQ-033 Misaligned access: store to 0x13, then load 0x10 -> store gives RespErr=1; load returns the prior value unchanged.
REQ-034 Out of range: load 0x800 with DEPTH_WORDS=512 and BASE_ADDR=0 -> RespErr=1 and RespRData=0; load 0x7FC -> RespErr=0.
REQ-035 Back-to-back requests: ReqValid held high for 9 cycles with 3 different addresses -> exactly 3 handshakes, on cycles 0, 3, 6; ReqReady=0 on all other cycles.
REQ-036 Reset mid-store: RESET=0 in the ACCESS cycle of a store of 0x1234 to 0x20 -> no RespValid; a later load of 0x20 returns 0.
REQ-037 Input stability: change ReqAddr and ReqWData on the cycle after a handshake -> the original captured address and data are used.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared CPU definitions used by the data-memory responder and its storage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_resp_pkg;

    // Default number of 32-bit words in the data memory.
    localparam int DEFAULT_DEPTH_WORDS = 512;

    // Responder FSM state encoding.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

endpackage

// File: rtl/word_ram.sv
// Synchronous single-port word array with a full clear on reset.
// Latency: read data registered on the enabling edge, visible the next cycle.
// Backpressure: none; accepts an access on every enabled cycle.
// Ports: i_clk/i_rst_n clock and sync active-low reset; i_en/i_we/i_addr/i_wdata
//        access controls; o_rdata registered load data (held until next read).
module word_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Reset wins over any access that lands on the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdata <= '0;
        end else if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder for the CPU MEM stage: one load/store per request.
// Latency: RespValid pulses 2 cycles after the handshake edge; 1 request per 3 cycles.
// Backpressure: ReqReady only in IDLE; ReqValid is ignored (not queued) while Busy.
// Ports: CLOCK/RESET (sync active-low); Req* request channel; Resp* one-cycle
//        completion with load data and error flag; Busy stalls the pipeline.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespRData,
    output logic        RespErr,
    output logic        Busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_write;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        w_req_rdy;
    logic        w_busy;
    logic        w_resp_vld;
    logic        w_do_access;
    logic        w_hs;
    logic [31:0] w_offset;
    logic [31:0] w_index;
    logic        w_err;
    logic [31:0] w_ram_rdata;
    logic        w_unused;

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_rdy   = 1'b0;
        w_busy      = 1'b0;
        w_resp_vld  = 1'b0;
        w_do_access = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_rdy = 1'b1;
                if (ReqValid) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                w_busy      = 1'b1;
                w_do_access = 1'b1;
                w_state_nxt = RESPOND;
            end
            RESPOND: begin
                w_busy      = 1'b1;
                w_resp_vld  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_hs = ReqValid & w_req_rdy;

    // Request is frozen at the handshake; the registers stay stable through
    // ACCESS and RESPOND because no new handshake can occur outside IDLE.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_hs) begin
            r_write <= ReqWrite;
            r_addr  <= ReqAddr;
            r_wdata <= ReqWData;
        end
    end

    // Offset wraps on underflow; the explicit addr < BASE term catches that case.
    assign w_offset = r_addr - BASE_ADDR;
    assign w_index  = w_offset >> 2;
    assign w_err    = (r_addr[1:0] != 2'b00)
                    | (r_addr < BASE_ADDR)
                    | (w_index >= 32'(DEPTH_WORDS));

    word_ram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_word_ram (
        .i_clk   (CLOCK),
        .i_rst_n (RESET),
        .i_en    (w_do_access & ~w_err),
        .i_we    (r_write),
        .i_addr  (w_index[AW-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_unused = &{1'b0, w_index[31:AW]};

    assign ReqReady  = w_req_rdy;
    assign Busy      = w_busy;
    assign RespValid = w_resp_vld;
    assign RespErr   = w_resp_vld & w_err;
    assign RespRData = (w_resp_vld & ~w_err & ~r_write) ? w_ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_resp.sv
module tb_data_mem_resp;

    localparam int          DEPTH = 512;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        ReqValid = 1'b0;
    logic        ReqReady;
    logic        ReqWrite = 1'b0;
    logic [31:0] ReqAddr = '0;
    logic [31:0] ReqWData = '0;
    logic        RespValid;
    logic [31:0] RespRData;
    logic        RespErr;
    logic        Busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] model_mem [DEPTH];

    data_mem_resp #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (BASE)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .ReqWrite  (ReqWrite),
        .ReqAddr   (ReqAddr),
        .ReqWData  (ReqWData),
        .RespValid (RespValid),
        .RespRData (RespRData),
        .RespErr   (RespErr),
        .Busy      (Busy)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic m_err(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a % 4 != 0) || (a < BASE) || ((off / 4) >= DEPTH);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endfunction

    // Apply a request to the model; returns expected error and load data.
    function automatic void m_access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                     output logic e, output logic [31:0] rd);
        e  = m_err(a);
        rd = '0;
        if (!e) begin
            if (wr) model_mem[m_idx(a)] = d;
            else    rd = model_mem[m_idx(a)];
        end
    endfunction

    // Issue one request and observe its completion. After the handshake the
    // request inputs are scrambled to a different, valid neighbouring word.
    // lat = negedges from handshake edge to RespValid (-1 when no response arrives);
    // after = RespValid on the cycle following the pulse.
    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic err,
                          output logic after);
        bit hs;
        bit seen;
        hs = 0; seen = 0; lat = -1; rd = '0; err = 1'b0; after = 1'b0;
        @(posedge CLOCK); #1;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddr = a; ReqWData = d;
        for (int i = 0; i < 8 && !hs; i++) begin
            @(negedge CLOCK);
            if (ReqReady) hs = 1;
        end
        if (hs) begin
            @(posedge CLOCK); #1;
            ReqValid = 1'b0;
            ReqAddr  = a ^ 32'h4;
            ReqWData = ~d;
            ReqWrite = ~wr;
            for (int c = 1; c <= 6 && !seen; c++) begin
                @(negedge CLOCK);
                if (RespValid) begin
                    seen = 1; lat = c; rd = RespRData; err = RespErr;
                    @(negedge CLOCK);
                    after = RespValid;
                end
            end
        end else begin
            ReqValid = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        checks += 5;
        if (ReqReady !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ReqReady); end
        if (RespValid !== 1'b0) begin errors++; $display("FAIL reset_respvalid: got %b want 0", RespValid); end
        if (RespRData !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", RespRData); end
        if (RespErr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", RespErr); end
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
        m_clear();
        @(posedge CLOCK); #1;
        RESET = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, e, af);
        m_access(1'b1, 32'h10, 32'hDEADBEEF, ee, er);
        checks += 4;
        if (lat !== 2) begin errors++; $display("FAIL basic_store_latency: got %0d want 2", lat); end
        if (af !== 1'b0) begin errors++; $display("FAIL basic_store_pulse: second cycle valid %b want 0", af); end
        if (e !== ee) begin errors++; $display("FAIL basic_store_err: got %b want %b", e, ee); end
        if (rd !== er) begin errors++; $display("FAIL basic_store_rdata: got %h want %h", rd, er); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, e, af);
        m_access(1'b0, 32'h10, 32'h0, ee, er);
        checks += 4;
        if (lat !== 2) begin errors++; $display("FAIL basic_load_latency: got %0d want 2", lat); end
        if (af !== 1'b0) begin errors++; $display("FAIL basic_load_pulse: second cycle valid %b want 0", af); end
        if (e !== 1'b0) begin errors++; $display("FAIL basic_load_err: got %b want 0", e); end
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_load_rdata: got %h want deadbeef", rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        do_req(1'b1, 32'h13, 32'hCAFEF00D, lat, rd, e, af);
        m_access(1'b1, 32'h13, 32'hCAFEF00D, ee, er);
        checks += 2;
        if (e !== 1'b1) begin errors++; $display("FAIL misaligned_err: got %b want 1", e); end
        if (rd !== 32'h0) begin errors++; $display("FAIL misaligned_rdata: got %h want 0", rd); end
        do_req(1'b0, 32'h10, 32'h0, lat, rd, e, af);
        m_access(1'b0, 32'h10, 32'h0, ee, er);
        checks += 2;
        if (e !== ee) begin errors++; $display("FAIL misaligned_reload_err: got %b want %b", e, ee); end
        if (rd !== er) begin errors++; $display("FAIL misaligned_reload_rdata: got %h want %h", rd, er); end
    endtask

    task automatic test_range();
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        logic [31:0] addrs [3];
        addrs[0] = 32'h800; addrs[1] = 32'h7FC; addrs[2] = 32'hFFFF_FFFC;
        do_req(1'b1, 32'h7FC, 32'h0BAD_F00D, lat, rd, e, af);
        m_access(1'b1, 32'h7FC, 32'h0BAD_F00D, ee, er);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, addrs[i], 32'h0, lat, rd, e, af);
            m_access(1'b0, addrs[i], 32'h0, ee, er);
            checks += 2;
            if (e !== ee) begin errors++; $display("FAIL range_err addr=%h: got %b want %b", addrs[i], e, ee); end
            if (rd !== er) begin errors++; $display("FAIL range_rdata addr=%h: got %h want %h", addrs[i], rd, er); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a [3];
        logic [31:0] d [3];
        int idx; int hs_cnt;
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        for (int i = 0; i < 3; i++) begin
            a[i] = 32'h100 + 32'(i * 4);
            d[i] = $urandom;
        end
        idx = 0; hs_cnt = 0;
        @(posedge CLOCK); #1;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = a[0]; ReqWData = d[0];
        for (int k = 0; k < 9; k++) begin
            @(negedge CLOCK);
            checks += 4;
            if (ReqReady !== ((k % 3) == 0)) begin errors++; $display("FAIL b2b_ready cycle %0d: got %b want %b", k, ReqReady, (k % 3) == 0); end
            if (Busy !== ((k % 3) != 0)) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b want %b", k, Busy, (k % 3) != 0); end
            if (RespValid !== ((k % 3) == 2)) begin errors++; $display("FAIL b2b_respvalid cycle %0d: got %b want %b", k, RespValid, (k % 3) == 2); end
            if (RespRData !== 32'h0 || RespErr !== 1'b0) begin errors++; $display("FAIL b2b_resp cycle %0d: got rdata=%h err=%b want 0/0", k, RespRData, RespErr); end
            if (ReqReady === 1'b1) hs_cnt++;
            @(posedge CLOCK); #1;
            if (ReqReady === 1'b0 && (k % 3) == 0) begin end
            if ((k % 3) == 0 && idx < 2) begin
                idx++;
                ReqAddr = a[idx]; ReqWData = d[idx];
            end
        end
        ReqValid = 1'b0;
        checks++;
        if (hs_cnt !== 3) begin errors++; $display("FAIL b2b_handshakes: got %0d want 3", hs_cnt); end
        for (int i = 0; i < 3; i++) m_access(1'b1, a[i], d[i], ee, er);
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, a[i], 32'h0, lat, rd, e, af);
            m_access(1'b0, a[i], 32'h0, ee, er);
            checks++;
            if (rd !== er || e !== ee) begin errors++; $display("FAIL b2b_readback addr=%h: got %h/%b want %h/%b", a[i], rd, e, er, ee); end
        end
    endtask

    task automatic test_reset_mid_store();
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        bit hs; int seen;
        do_req(1'b1, 32'h40, 32'h5555AAAA, lat, rd, e, af);
        m_access(1'b1, 32'h40, 32'h5555AAAA, ee, er);
        hs = 0; seen = 0;
        @(posedge CLOCK); #1;
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqAddr = 32'h20; ReqWData = 32'h1234;
        for (int i = 0; i < 8 && !hs; i++) begin
            @(negedge CLOCK);
            if (ReqReady) hs = 1;
        end
        checks++;
        if (!hs) begin errors++; $display("FAIL midreset_handshake: got none want 1"); end
        @(posedge CLOCK); #1;
        ReqValid = 1'b0;
        RESET = 1'b0;
        @(posedge CLOCK); #1;
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLOCK);
            if (RespValid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_respvalid: got %0d pulses want 0", seen); end
        m_clear();
        do_req(1'b0, 32'h20, 32'h0, lat, rd, e, af);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL midreset_load20: got %h/%b want 0/0", rd, e); end
        do_req(1'b0, 32'h40, 32'h0, lat, rd, e, af);
        checks++;
        if (rd !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL midreset_load40: got %h/%b want 0/0", rd, e); end
    endtask

    task automatic test_stability();
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        logic [31:0] v;
        v = $urandom;
        // do_req moves ReqAddr to 0x304 and inverts ReqWData right after the handshake.
        do_req(1'b1, 32'h300, v, lat, rd, e, af);
        m_access(1'b1, 32'h300, v, ee, er);
        do_req(1'b0, 32'h300, 32'h0, lat, rd, e, af);
        checks++;
        if (rd !== v) begin errors++; $display("FAIL stability_load300: got %h want %h", rd, v); end
        do_req(1'b0, 32'h304, 32'h0, lat, rd, e, af);
        m_access(1'b0, 32'h304, 32'h0, ee, er);
        checks++;
        if (rd !== er) begin errors++; $display("FAIL stability_load304: got %h want %h", rd, er); end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd; logic e; logic af; logic ee; logic [31:0] er;
        logic [31:0] a; logic [31:0] d; logic wr; int kind;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            wr   = 1'($urandom_range(0, 1));
            d    = $urandom;
            if (kind <= 5)      a = 32'h200 + 32'($urandom_range(0, 7) * 4);
            else if (kind == 6) a = 32'h200 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(1, 3));
            else if (kind == 7) a = 32'h800 + 32'($urandom_range(0, 255) * 4);
            else if (kind == 8) a = 32'h7FC;
            else                a = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
            do_req(wr, a, d, lat, rd, e, af);
            m_access(wr, a, d, ee, er);
            checks += 4;
            if (lat !== 2) begin errors++; $display("FAIL rand_latency #%0d: got %0d want 2", n, lat); end
            if (af !== 1'b0) begin errors++; $display("FAIL rand_pulse #%0d: second cycle valid %b want 0", n, af); end
            if (e !== ee) begin errors++; $display("FAIL rand_err #%0d addr=%h: got %b want %b", n, a, e, ee); end
            if (rd !== er) begin errors++; $display("FAIL rand_rdata #%0d addr=%h: got %h want %h", n, a, rd, er); end
        end
    endtask

    initial begin
        m_clear();
        test_reset();
        test_basic();
        test_misaligned();
        test_range();
        test_back_to_back();
        test_reset_mid_store();
        test_stability();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
